z80_bus_target: RTL and testbench

Synchronous Z80-bus target that answers memory and I/O cycles issued by the TV80 bus wrapper on the shared system clock. It decodes one memory window and one I/O window, stretches the CPU cycle with `wait_n` until a local register-bus handshake completes, and returns read data. It also supplies the IM2 interrupt vector during interrupt-acknowledge cycles. It sits between the CPU bus and PC-8001 peripheral register blocks.

---
 rtl/z80_bus_target.sv | 161 ++++++++++++++++
 tb/tb_z80_bus_target.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_target.sv
// Purpose : Z80-bus target that decodes one memory and one I/O window and bridges hits onto a local register bus.
// Latency : loc_req one clk after the hit is seen; wait_n low for N+2 clks when the ack comes N clks after loc_req.
// Backpres: the CPU is stretched with wait_n until loc_ack or the timeout; no new hit is taken until all strobes release.
//
// Ports:
//   clk, reset          system clock (shared with the CPU), synchronous active-high reset
//   m1_n .. wr_n, A, di CPU bus strobes (active low), address and write data
//   dout, do_oe         read/vector data to the CPU and its drive enable
//                       (the CPU-side "do" bus; "do" is a SystemVerilog keyword)
//   wait_n              combinational cycle stretch, active low
//   int_n               interrupt request to the CPU, active low
//   loc_*               local register bus: one-cycle loc_req with latched
//                       address, write data and space; loc_ack/loc_rdata back
//   irq_req/irq_vector  level interrupt request and IM2 vector; irq_ack pulse
//   timeout_err         one-cycle pulse when a local access times out
// Optional feature: define Z80_BUS_TARGET_IM2_EN to enable int_n, IM2
// interrupt-acknowledge handling and irq_ack. Undefined, int_n is held 1,
// irq_ack is held 0 and acknowledge cycles are ignored.
module z80_bus_target #(
  parameter logic [7:0]  IO_BASE  = 8'h40,
  parameter logic [7:0]  IO_MASK  = 8'hF0,
  parameter logic [15:0] MEM_BASE = 16'hF000,
  parameter logic [15:0] MEM_MASK = 16'hF000,
  parameter logic [7:0]  TIMEOUT  = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] A,
  input  logic [7:0]  di,
  output logic [7:0]  dout,
  output logic        do_oe,
  output logic        wait_n,
  output logic        int_n,
  output logic        loc_req,
  output logic        loc_we,
  output logic        loc_io,
  output logic [15:0] loc_addr,
  output logic [7:0]  loc_wdata,
  input  logic        loc_ack,
  input  logic [7:0]  loc_rdata,
  input  logic        irq_req,
  input  logic [7:0]  irq_vector,
  output logic        irq_ack,
  output logic        timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_INTA} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       mem_hit;
  logic       io_hit;
  logic       any_hit;
  logic       strobes_idle;
  logic       irq_ack_q;

  // Refresh cycles have neither rd_n nor wr_n low, so they never hit.
  assign mem_hit      = !mreq_n && (!rd_n || !wr_n) && ((A & MEM_MASK) == MEM_BASE);
  assign io_hit       = !iorq_n && m1_n && (!rd_n || !wr_n) && ((A[7:0] & IO_MASK) == IO_BASE);
  assign any_hit      = mem_hit || io_hit;
  assign strobes_idle = rd_n && wr_n && mreq_n && iorq_n;

`ifdef Z80_BUS_TARGET_IM2_EN
  logic inta_cyc;
  assign inta_cyc = !m1_n && !iorq_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      dout        <= 8'h00;
      loc_req     <= 1'b0;
      loc_we      <= 1'b0;
      loc_io      <= 1'b0;
      loc_addr    <= 16'h0000;
      loc_wdata   <= 8'h00;
      irq_ack_q   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      loc_req     <= 1'b0;
      irq_ack_q   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_hit) begin
            // Latch everything at hit time; memory write data is already
            // valid because wr_n is low when the hit is first seen.
            loc_addr  <= A;
            loc_wdata <= di;
            loc_we    <= !wr_n;
            loc_io    <= io_hit;
            loc_req   <= 1'b1;
            state     <= S_REQ;
          end
`ifdef Z80_BUS_TARGET_IM2_EN
          else if (inta_cyc) begin
            dout      <= irq_vector;
            irq_ack_q <= 1'b1;
            state     <= S_INTA;
          end
`endif
        end
        S_REQ: begin
          cnt <= TIMEOUT;
          if (loc_ack) begin
            dout  <= loc_rdata;
            state <= S_HOLD;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 8'd1;
          // An ack in the final counted cycle still wins over the timeout.
          if (loc_ack) begin
            dout  <= loc_rdata;
            state <= S_HOLD;
          end else if (cnt <= 8'd1) begin
            dout        <= 8'hFF;
            timeout_err <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Acks arriving here (late after a timeout) are ignored.
          if (strobes_idle) state <= S_IDLE;
        end
        S_INTA: begin
          dout <= irq_vector;
          if (iorq_n) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Combinational so it falls in the same phase as mreq_n/iorq_n.
  assign wait_n = reset ? 1'b1
                        : !(((state == S_IDLE) && any_hit) || (state == S_REQ) || (state == S_WAIT));
  assign do_oe  = ((state == S_HOLD) && !rd_n) || (state == S_INTA);

`ifdef Z80_BUS_TARGET_IM2_EN
  always_ff @(posedge clk) begin
    if (reset) int_n <= 1'b1;
    else       int_n <= !irq_req;
  end
  assign irq_ack = irq_ack_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_req, irq_vector, irq_ack_q};
  assign int_n      = 1'b1;
  assign irq_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_target.sv
module tb_z80_bus_target;

  localparam logic [7:0] T     = 8'd4;
  localparam int         NEVER = 255;
  localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3, K_RFSH = 4;
`ifdef Z80_BUS_TARGET_IM2_EN
  localparam bit IM2 = 1'b1;
`else
  localparam bit IM2 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic [15:0] A;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        do_oe, wait_n, int_n;
  logic        loc_req, loc_we, loc_io;
  logic [15:0] loc_addr;
  logic [7:0]  loc_wdata;
  logic        loc_ack;
  logic [7:0]  loc_rdata;
  logic        irq_req;
  logic [7:0]  irq_vector;
  logic        irq_ack, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z80_bus_target #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .A(A), .di(di), .dout(dout), .do_oe(do_oe),
    .wait_n(wait_n), .int_n(int_n), .loc_req(loc_req), .loc_we(loc_we),
    .loc_io(loc_io), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_ack(loc_ack), .loc_rdata(loc_rdata), .irq_req(irq_req),
    .irq_vector(irq_vector), .irq_ack(irq_ack), .timeout_err(timeout_err)
  );

  // Reference decode: memory window is the top 4 KB page, I/O window is
  // ports 0x40..0x4F of the low address byte. Refresh never hits.
  function automatic bit model_hit(input int kind, input logic [15:0] a);
    int lo;
    lo = int'(a) % 256;
    case (kind)
      K_MRD, K_MWR: return int'(a) >= 61440;
      K_IRD, K_IWR: return (lo >= 64) && (lo < 80);
      default:      return 1'b0;
    endcase
  endfunction

  // Drives one CPU bus cycle, plays the local responder with ack latency
  // lat (NEVER = no ack) and reports what the CPU and local bus observed.
  task automatic cpu_cycle(input int kind, input logic [15:0] addr, input logic [7:0] wd,
                           input int lat, input logic [7:0] rdat, input int gap,
                           output int nreq, output int nlow, output int nto,
                           output logic oe, output logic [7:0] data,
                           output logic [15:0] q_addr, output logic q_we, output logic q_io,
                           output logic [7:0] q_wd, output int post_bad);
    int reqcyc;
    bit done;
    nreq = 0; nlow = 0; nto = 0; post_bad = 0; reqcyc = -1; done = 1'b0;
    oe = 1'b0; data = 8'h00; q_addr = 16'h0; q_we = 1'b0; q_io = 1'b0; q_wd = 8'h0;
    @(posedge clk); #1;
    A = addr; di = wd; m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    case (kind)
      K_MRD:   begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'($urandom_range(0, 1)); end
      K_MWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IRD:   begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IWR:   begin iorq_n = 1'b0; wr_n = 1'b0; end
      default: begin mreq_n = 1'b0; end
    endcase
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!wait_n) nlow++;
      if (loc_req) begin
        nreq++; reqcyc = c;
        q_addr = loc_addr; q_we = loc_we; q_io = loc_io; q_wd = loc_wdata;
      end
      if (timeout_err) nto++;
      loc_ack   = (reqcyc >= 0) && (lat != NEVER) && (c == reqcyc + lat);
      loc_rdata = loc_ack ? rdat : 8'($urandom);
      if (wait_n) begin done = 1'b1; oe = do_oe; data = dout; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cycle_bound: wait_n still low after 40 clks, required release");
    end
    @(posedge clk); #1;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; loc_ack = 1'b0;
    for (int c = 0; c < gap; c++) begin
      @(negedge clk);
      if (!wait_n || do_oe) post_bad++;
      if (loc_req) nreq++;
      if (timeout_err) nto++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout, do_oe, loc_req, loc_we, loc_io, irq_ack, timeout_err, int_n, wait_n} !== {8'h00, 8'b0000_0011}) begin
      errors++;
      $display("FAIL reset_ctrl: got dout=%h oe=%b req=%b we=%b io=%b iack=%b to=%b int_n=%b wait_n=%b, required 00/0/0/0/0/0/0/1/1",
               dout, do_oe, loc_req, loc_we, loc_io, irq_ack, timeout_err, int_n, wait_n);
    end
    checks++;
    if ({loc_addr, loc_wdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_lat: got addr=%h wdata=%h, required 0000/00", loc_addr, loc_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_io_read();
    int nreq, nlow, nto, pb; logic oe, qwe, qio; logic [7:0] d, qwd; logic [15:0] qa;
    cpu_cycle(K_IRD, 16'h0045, 8'h11, 3, 8'h5A, 3, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
    checks++;
    if (nreq != 1 || qio !== 1'b1 || qwe !== 1'b0 || qa !== 16'h0045) begin
      errors++;
      $display("FAIL io_read_req: got n=%0d io=%b we=%b addr=%h, required 1/1/0/0045", nreq, qio, qwe, qa);
    end
    checks++;
    if (nlow != 5) begin errors++; $display("FAIL io_read_wait: got %0d clks low, required 5", nlow); end
    checks++;
    if (oe !== 1'b1 || d !== 8'h5A) begin
      errors++; $display("FAIL io_read_data: got oe=%b data=%h, required 1/5a", oe, d);
    end
  endtask

  task automatic test_mem_write();
    int nreq, nlow, nto, pb; logic oe, qwe, qio; logic [7:0] d, qwd; logic [15:0] qa;
    cpu_cycle(K_MWR, 16'hF123, 8'hC3, 0, 8'h77, 3, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
    checks++;
    if (nreq != 1 || qwe !== 1'b1 || qio !== 1'b0 || qwd !== 8'hC3 || qa !== 16'hF123) begin
      errors++;
      $display("FAIL mem_write_req: got n=%0d we=%b io=%b wdata=%h addr=%h, required 1/1/0/c3/f123", nreq, qwe, qio, qwd, qa);
    end
    checks++;
    if (nlow != 2 || oe !== 1'b0 || pb != 0) begin
      errors++; $display("FAIL mem_write_wait: got low=%0d oe=%b post=%0d, required 2/0/0", nlow, oe, pb);
    end
  endtask

  task automatic test_miss();
    int nreq, nlow, nto, pb; logic oe, qwe, qio; logic [7:0] d, qwd; logic [15:0] qa;
    cpu_cycle(K_MRD, 16'h1000, 8'h00, 0, 8'h33, 2, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
    checks++;
    if (nreq != 0 || nlow != 0 || oe !== 1'b0) begin
      errors++; $display("FAIL miss_read: got req=%0d low=%0d oe=%b, required 0/0/0", nreq, nlow, oe);
    end
    cpu_cycle(K_RFSH, 16'hF000, 8'h00, 0, 8'h33, 2, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
    checks++;
    if (nreq != 0 || nlow != 0 || oe !== 1'b0) begin
      errors++; $display("FAIL miss_refresh: got req=%0d low=%0d oe=%b, required 0/0/0", nreq, nlow, oe);
    end
  endtask

  task automatic test_timeout();
    int nreq, nlow, nto, pb; logic oe, qwe, qio; logic [7:0] d, qwd; logic [15:0] qa;
    cpu_cycle(K_MRD, 16'hF055, 8'h00, NEVER, 8'h00, 4, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
    checks++;
    if (nto != 1 || nreq != 1) begin
      errors++; $display("FAIL timeout_pulse: got pulses=%0d req=%0d, required 1/1", nto, nreq);
    end
    checks++;
    if (oe !== 1'b1 || d !== 8'hFF || nlow != int'(T) + 2) begin
      errors++; $display("FAIL timeout_data: got oe=%b data=%h low=%0d, required 1/ff/%0d", oe, d, nlow, int'(T) + 2);
    end
    checks++;
    if (pb != 0) begin errors++; $display("FAIL timeout_idle: got %0d busy clks after release, required 0", pb); end
  endtask

  task automatic test_random(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int kind, lat, nreq, nlow, nto, pb, el;
      logic [15:0] a, qa; logic [7:0] wd, rd, d, qwd; logic oe, qwe, qio;
      bit hit, acked, is_rd;
      kind = $urandom_range(0, 4);
      a    = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        if (kind <= K_MWR) a[15:12] = 4'hF; else a[7:4] = 4'h4;
      end
      wd  = 8'($urandom);
      rd  = 8'($urandom);
      lat = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, int'(T) + 2);
      cpu_cycle(kind, a, wd, lat, rd, gap, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
      hit   = model_hit(kind, a);
      acked = hit && (lat <= int'(T));
      is_rd = (kind == K_MRD) || (kind == K_IRD);
      el    = !hit ? 0 : (acked ? lat + 2 : int'(T) + 2);
      checks++;
      if (nreq != int'(hit) || nlow != el || nto != int'(hit && !acked)) begin
        errors++;
        $display("FAIL rnd%0d_flow: kind=%0d a=%h lat=%0d got req=%0d low=%0d to=%0d, required %0d/%0d/%0d",
                 i, kind, a, lat, nreq, nlow, nto, int'(hit), el, int'(hit && !acked));
      end
      checks++;
      if (oe !== (hit && is_rd) || (hit && is_rd && d !== (acked ? rd : 8'hFF))) begin
        errors++;
        $display("FAIL rnd%0d_data: got oe=%b data=%h, required oe=%b data=%h",
                 i, oe, d, hit && is_rd, acked ? rd : 8'hFF);
      end
      if (hit) begin
        checks++;
        if (qa !== a || qwe !== !is_rd || qio !== (kind >= K_IRD) || qwd !== wd) begin
          errors++;
          $display("FAIL rnd%0d_latch: got a=%h we=%b io=%b wd=%h, required %h/%b/%b/%h",
                   i, qa, qwe, qio, qwd, a, !is_rd, kind >= K_IRD, wd);
        end
      end
      checks++;
      if (pb != 0) begin errors++; $display("FAIL rnd%0d_idle: got %0d busy clks after release, required 0", i, pb); end
    end
  endtask

  task automatic test_back_to_back();
    test_random(16, 0);
    test_random(1, 2);
  endtask

  task automatic test_interrupt();
    int nack, noe, bad, wlow;
    irq_vector = 8'hE4;
    irq_req    = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (int_n !== !IM2) begin errors++; $display("FAIL int_assert: got int_n=%b, required %b", int_n, !IM2); end
    @(posedge clk); #1;
    m1_n = 1'b0; iorq_n = 1'b0;
    nack = 0; noe = 0; bad = 0; wlow = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (irq_ack) nack++;
      if (!wait_n) wlow++;
      if (do_oe) begin noe++; if (dout !== 8'hE4) bad++; end
    end
    checks++;
    if (nack != int'(IM2) || noe != (IM2 ? 3 : 0) || bad != 0) begin
      errors++;
      $display("FAIL inta_cycle: got acks=%0d oe_clks=%0d bad_vec=%0d, required %0d/%0d/0", nack, noe, bad, int'(IM2), IM2 ? 3 : 0);
    end
    checks++;
    if (wlow != 0) begin errors++; $display("FAIL inta_wait: got %0d clks low, required 0", wlow); end
    @(posedge clk); #1;
    m1_n = 1'b1; iorq_n = 1'b1; irq_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (do_oe !== 1'b0 || int_n !== 1'b1) begin
      errors++; $display("FAIL inta_release: got oe=%b int_n=%b, required 0/1", do_oe, int_n);
    end
  endtask

  task automatic test_reset_mid_wait();
    int nreq, nlow, nto, pb, stray; logic oe, qwe, qio; logic [7:0] d, qwd; logic [15:0] qa;
    @(posedge clk); #1;
    A = 16'hF010; mreq_n = 1'b0; rd_n = 1'b0; loc_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wait_n !== 1'b0) begin errors++; $display("FAIL rst_pre: got wait_n=%b, required 0", wait_n); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_forced: got wait_n=%b, required 1", wait_n); end
    @(posedge clk); #1;
    mreq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({dout, do_oe, loc_req, loc_we, loc_io, timeout_err, int_n, wait_n, loc_addr, loc_wdata} !==
        {8'h00, 7'b0000011, 16'h0000, 8'h00}) begin
      errors++;
      $display("FAIL rst_values: got dout=%h oe=%b req=%b to=%b addr=%h wait_n=%b, required 00/0/0/0/0000/1",
               dout, do_oe, loc_req, timeout_err, loc_addr, wait_n);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (loc_req || timeout_err || !wait_n) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rst_abandon: got %0d stray clks, required 0", stray); end
    cpu_cycle(K_MRD, 16'hF0AA, 8'h00, 1, 8'h9C, 3, nreq, nlow, nto, oe, d, qa, qwe, qio, qwd, pb);
    checks++;
    if (nreq != 1 || d !== 8'h9C || nlow != 3) begin
      errors++; $display("FAIL rst_next: got req=%0d data=%h low=%0d, required 1/9c/3", nreq, d, nlow);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    A = 16'h0; di = 8'h0; loc_ack = 1'b0; loc_rdata = 8'h0; irq_req = 1'b0; irq_vector = 8'h0;
    test_reset();
    test_io_read();
    test_mem_write();
    test_miss();
    test_timeout();
    test_random(40, 2);
    test_back_to_back();
    test_interrupt();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
